// File: rtl/pair_loop_gen.sv
// pair_loop_gen
// Nested-loop address generator for the tracklet stub-pair engines. Each start
// pulse latches the event sizes and walks every (outer, inner) address pair,
// one pair per accepted (valid && ready) cycle. In rectangular mode it covers
// memory 1 x memory 2. In triangle mode it covers the unique pairs i<j of
// memory 1 only.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 one-cycle pulse, (re)starts an event loop
//   number1in, number2in  entry counts of memory 1 / memory 2, sampled at start
//   triangle              sampled at start; 1 = unique pairs within memory 1
//   ready                 downstream accepts the presented pair
//   readadd1, readadd2    outer / inner read address of the presented pair
//   valid, last           pair present / pair is the final one of the event
//   busy                  loop in progress
//   done                  one-cycle pulse when the loop completes
//   pair_count            pairs accepted since the last start
module pair_loop_gen #(
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] number1in,
    input  logic [ADDR_W-1:0] number2in,
    input  logic              triangle,
    input  logic              ready,
    output logic [ADDR_W-1:0] readadd1,
    output logic [ADDR_W-1:0] readadd2,
    output logic              valid,
    output logic              last,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pair_count
);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONES = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_TWO  = {{(ADDR_W-2){1'b0}}, 2'b10};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] n1_r, n1_s;
    logic [ADDR_W-1:0] n2_r, n2_s;
    logic              tri_mode_r, tri_mode_s;
    logic [ADDR_W-1:0] addr1_s, addr2_s;
    logic              valid_s, last_s, busy_s, done_s;
    logic [CNT_W-1:0]  count_s;
    logic [ADDR_W-1:0] start_n2_s;
    logic [ADDR_W-1:0] start_j0_s;
    logic              start_empty_s;
    logic              inner_wrap_s;
    logic [ADDR_W-1:0] next_i_s, next_j_s;

    // True when (i, j) is the final pair of an event with sizes n1/n2. The
    // callers only use it for non-empty events, so n-1 and n-2 never wrap.
    function automatic logic is_final_pair(
        input logic [ADDR_W-1:0] i,
        input logic [ADDR_W-1:0] j,
        input logic [ADDR_W-1:0] n1,
        input logic [ADDR_W-1:0] n2,
        input logic              tri_mode
    );
        logic [ADDR_W-1:0] i_last;
        i_last = tri_mode ? (n1 - ADDR_TWO) : (n1 - ADDR_ONE);
        return (i == i_last) && (j == (n2 - ADDR_ONE));
    endfunction

    // Next-state and next-output logic for the loop controller.
    always_comb begin
        state_s    = state_r;
        n1_s       = n1_r;
        n2_s       = n2_r;
        tri_mode_s = tri_mode_r;
        addr1_s    = readadd1;
        addr2_s    = readadd2;
        valid_s    = valid;
        last_s     = last;
        busy_s     = busy;
        done_s     = 1'b0;
        count_s    = pair_count;

        // In triangle mode both loops index memory 1.
        start_n2_s    = triangle ? number1in : number2in;
        start_j0_s    = triangle ? ADDR_ONE : ADDR_ZERO;
        start_empty_s = (number1in == ADDR_ZERO) || (start_n2_s == ADDR_ZERO) ||
                        (triangle && (number1in < ADDR_TWO));

        // Successor of the presented pair; the inner index varies fastest and
        // restarts at i+1 for the next outer index in triangle mode.
        inner_wrap_s = (readadd2 == (n2_r - ADDR_ONE));
        if (inner_wrap_s) begin
            next_i_s = readadd1 + ADDR_ONE;
            next_j_s = tri_mode_r ? (readadd1 + ADDR_TWO) : ADDR_ZERO;
        end else begin
            next_i_s = readadd1;
            next_j_s = readadd2 + ADDR_ONE;
        end

        // A start always wins, including over a final acceptance in RUN.
        if (start) begin
            n1_s       = number1in;
            n2_s       = start_n2_s;
            tri_mode_s = triangle;
            count_s    = CNT_ZERO;
            if (start_empty_s) begin
                state_s = IDLE;
                addr1_s = ADDR_ONES;
                addr2_s = ADDR_ONES;
                valid_s = 1'b0;
                last_s  = 1'b0;
                busy_s  = 1'b0;
                done_s  = 1'b1;
            end else begin
                state_s = RUN;
                addr1_s = ADDR_ZERO;
                addr2_s = start_j0_s;
                valid_s = 1'b1;
                last_s  = is_final_pair(ADDR_ZERO, start_j0_s, number1in, start_n2_s, triangle);
                busy_s  = 1'b1;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                RUN: begin
                    if (valid && ready) begin
                        count_s = pair_count + CNT_ONE;
                        if (last) begin
                            // Addresses keep showing the final pair.
                            state_s = IDLE;
                            valid_s = 1'b0;
                            last_s  = 1'b0;
                            busy_s  = 1'b0;
                            done_s  = 1'b1;
                        end else begin
                            addr1_s = next_i_s;
                            addr2_s = next_j_s;
                            last_s  = is_final_pair(next_i_s, next_j_s, n1_r, n2_r, tri_mode_r);
                        end
                    end else begin
                        state_s = RUN;
                    end
                end
                default: begin
                    state_s = IDLE;
                    valid_s = 1'b0;
                    last_s  = 1'b0;
                    busy_s  = 1'b0;
                end
            endcase
        end
    end

    // State, latched event parameters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            n1_r       <= ADDR_ZERO;
            n2_r       <= ADDR_ZERO;
            tri_mode_r <= 1'b0;
            readadd1   <= ADDR_ONES;
            readadd2   <= ADDR_ONES;
            valid      <= 1'b0;
            last       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pair_count <= CNT_ZERO;
        end else begin
            state_r    <= state_s;
            n1_r       <= n1_s;
            n2_r       <= n2_s;
            tri_mode_r <= tri_mode_s;
            readadd1   <= addr1_s;
            readadd2   <= addr2_s;
            valid      <= valid_s;
            last       <= last_s;
            busy       <= busy_s;
            done       <= done_s;
            pair_count <= count_s;
        end
    end

endmodule

// File: tb/tb_pair_loop_gen.sv
// tb_pair_loop_gen
// Self-checking bench for pair_loop_gen. The expected pair sequence of every
// event is enumerated directly from its definition (all i x j, or all i<j)
// into queues. The DUT output is then compared against it cycle by cycle.
module tb_pair_loop_gen;

    localparam int AW = 6;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] number1in = '0;
    logic [AW-1:0] number2in = '0;
    logic          triangle = 1'b0;
    logic          ready = 1'b0;
    logic [AW-1:0] readadd1, readadd2;
    logic          valid, last, busy, done;
    logic [CW-1:0] pair_count;

    int total = 0;
    int bad = 0;
    int exp1[$];
    int exp2[$];

    pair_loop_gen #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .number1in(number1in), .number2in(number2in), .triangle(triangle),
        .ready(ready), .readadd1(readadd1), .readadd2(readadd2),
        .valid(valid), .last(last), .busy(busy), .done(done),
        .pair_count(pair_count)
    );

    always #5 clk = ~clk;

    // Reference: list every pair the event must produce, in order.
    task automatic build_model(input int n1, input int n2, input bit tr);
        exp1.delete();
        exp2.delete();
        for (int i = 0; i < n1; i++) begin
            for (int j = (tr ? i + 1 : 0); j < (tr ? n1 : n2); j++) begin
                exp1.push_back(i);
                exp2.push_back(j);
            end
        end
    endtask

    // Runs one event from the current negedge. ready_mode: 0 always ready,
    // 1 random, 2 low on RUN cycles 2..4. abort_after >= 0 returns after that
    // many accepted pairs, leaving the loop running.
    task automatic run_event(input string name, input int n1, input int n2, input bit tr,
                             input int ready_mode, input int abort_after);
        int idx;
        int cyc;
        int size;
        int e1;
        int e2;
        bit el;
        idx = 0;
        cyc = 0;
        build_model(n1, n2, tr);
        size = exp1.size();
        number1in = AW'(n1);
        number2in = AW'(n2);
        triangle = tr;
        start = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        number1in = AW'($urandom);
        number2in = AW'($urandom);
        triangle = 1'($urandom);
        while (idx < size && (abort_after < 0 || idx < abort_after) && cyc < 20000) begin
            e1 = exp1[idx];
            e2 = exp2[idx];
            el = (idx == size - 1);
            total++;
            if (valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || last !== el ||
                readadd1 !== AW'(e1) || readadd2 !== AW'(e2)) begin
                bad++;
                $display("FAIL %s pair%0d: got a1=%0d a2=%0d v=%b l=%b b=%b d=%b, want a1=%0d a2=%0d v=1 l=%b b=1 d=0",
                         name, idx, readadd1, readadd2, valid, last, busy, done, e1, e2, el);
            end
            total++;
            if (pair_count !== CW'(idx)) begin
                bad++;
                $display("FAIL %s count%0d: got %0d want %0d", name, idx, pair_count, idx);
            end
            case (ready_mode)
                0: ready = 1'b1;
                1: ready = 1'($urandom_range(0, 1));
                default: ready = !(cyc >= 1 && cyc <= 3);
            endcase
            if (ready) idx++;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 20000) begin
            total++;
            bad++;
            $display("FAIL %s timeout: got %0d pairs want %0d", name, idx, size);
        end
        if (abort_after >= 0) return;
        e1 = (size == 0) ? (1 << AW) - 1 : exp1[size - 1];
        e2 = (size == 0) ? (1 << AW) - 1 : exp2[size - 1];
        ready = 1'($urandom_range(0, 1));
        total++;
        if (valid !== 1'b0 || last !== 1'b0 || busy !== 1'b0 || done !== 1'b1 ||
            pair_count !== CW'(size) || readadd1 !== AW'(e1) || readadd2 !== AW'(e2)) begin
            bad++;
            $display("FAIL %s done: got v=%b l=%b b=%b d=%b cnt=%0d a1=%0d a2=%0d, want v=0 l=0 b=0 d=1 cnt=%0d a1=%0d a2=%0d",
                     name, valid, last, busy, done, pair_count, readadd1, readadd2, size, e1, e2);
        end
        @(negedge clk);
        total++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            pair_count !== CW'(size) || readadd1 !== AW'(e1) || readadd2 !== AW'(e2)) begin
            bad++;
            $display("FAIL %s after_done: got v=%b b=%b d=%b cnt=%0d a1=%0d a2=%0d, want v=0 b=0 d=0 cnt=%0d a1=%0d a2=%0d",
                     name, valid, busy, done, pair_count, readadd1, readadd2, size, e1, e2);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (readadd1 !== '1 || readadd2 !== '1 || valid !== 1'b0 || last !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || pair_count !== '0) begin
            bad++;
            $display("FAIL reset: got a1=%0d a2=%0d v=%b l=%b b=%b d=%b cnt=%0d, want all ones and zeros",
                     readadd1, readadd2, valid, last, busy, done, pair_count);
        end
        reset_n = 1'b1;
        ready = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pair_count !== '0) begin
            bad++;
            $display("FAIL idle_wait: got v=%b b=%b d=%b cnt=%0d, want 0 0 0 0", valid, busy, done, pair_count);
        end
    endtask

    task automatic test_basic();
        run_event("rect3x2", 3, 2, 1'b0, 0, -1);
        run_event("single", 1, 1, 1'b0, 0, -1);
    endtask

    task automatic test_triangle();
        run_event("tri4", 4, 9, 1'b1, 0, -1);
        run_event("tri2", 2, 0, 1'b1, 0, -1);
    endtask

    task automatic test_empty();
        run_event("empty_n2", 5, 0, 1'b0, 0, -1);
        run_event("empty_n1", 0, 5, 1'b0, 0, -1);
        run_event("empty_tri1", 1, 7, 1'b1, 0, -1);
    endtask

    task automatic test_stall();
        run_event("stall2x3", 2, 3, 1'b0, 2, -1);
    endtask

    task automatic test_back_to_back();
        run_event("abort4x4", 4, 4, 1'b0, 0, 5);
        run_event("restart2x1", 2, 1, 1'b0, 0, -1);
    endtask

    task automatic test_reset_mid_run();
        run_event("pre_reset", 3, 3, 1'b0, 0, 4);
        reset_n = 1'b0;
        #1;
        total++;
        if (readadd1 !== '1 || readadd2 !== '1 || valid !== 1'b0 || last !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || pair_count !== '0) begin
            bad++;
            $display("FAIL mid_reset: got a1=%0d a2=%0d v=%b l=%b b=%b d=%b cnt=%0d, want all ones and zeros",
                     readadd1, readadd2, valid, last, busy, done, pair_count);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pair_count !== '0) begin
                bad++;
                $display("FAIL post_reset%0d: got v=%b b=%b d=%b cnt=%0d, want 0 0 0 0",
                         k, valid, busy, done, pair_count);
            end
        end
    endtask

    task automatic test_max();
        run_event("max_tri", 63, 5, 1'b1, 0, -1);
        run_event("max_rect", 63, 2, 1'b0, 1, -1);
    endtask

    task automatic test_random();
        for (int e = 0; e < 12; e++) begin
            run_event("random", $urandom_range(0, 6), $urandom_range(0, 6),
                      1'($urandom_range(0, 1)), 1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_triangle();
        test_empty();
        test_stall();
        test_back_to_back();
        test_reset_mid_run();
        test_max();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
